mult_div_unit: RTL
==================

Name: mult_div_unit

Overview:
- Multi-cycle HI/LO multiply/divide unit, directly downstream of the general purpose register file.
- Consumes the two GPR read results (rs, rt) and executes MULT/MULTU/DIV/DIVU/MTHI/MTLO.
- Holds the architectural HI/LO registers and drives `busy` so the core stalls PC and writeback until the result is ready.
- MFHI/MFLO read `hi`/`lo` combinationally.

Parameters:
- MUL_LATENCY, 4, cycles from accepted multiply start to result in HI/LO; legal range 1..8.
- DIV_ITER_PER_CYCLE, 1, restoring-divider quotient bits resolved per cycle; legal values 1, 2, 4.

Ports:
- clock  input  1  system clock; all state updates on posedge.
- reset  input  1  synchronous, active-high.
- start  input  1  request to execute `op` this cycle.
- op  input  4  MdOp code (package enum).
- operandA  input  32  rs value (gprResult1).
- operandB  input  32  rt value (gprResult2).
- busy  output  1  operation in flight; core must stall.
- done  output  1  one-cycle pulse in the cycle HI/LO hold a new mult/div result.
- hi  output  32  HI register.
- lo  output  32  LO register.

Behaviour:
- Reset: synchronous on posedge when reset=1. hi=0, lo=0, busy=0, done=0, FSM=IDLE, counter=0. Reset mid-operation aborts it; no partial result is written.
- FSM states: IDLE, MUL, DIV, FIN.
- IDLE:
  - start with MULT/MULTU: latch operands, go to MUL.
  - start with DIV/DIVU: latch operands, go to DIV.
  - start with MTHI: hi<=operandA at the edge; stay IDLE; busy stays 0; no done.
  - start with MTLO: lo<=operandA, same rules as MTHI.
  - start with NONE or an unused code: ignored.
- busy=1 combinationally in the same cycle start is accepted for MUL/DIV, and in every cycle in MUL and DIV. busy=0 in IDLE and FIN.
- MUL:
  - Product formed from latched operands; signed for MULT, unsigned for MULTU; full 64 bits.
  - After MUL_LATENCY cycles counted from the accept edge, {hi,lo}<=product; go to FIN.
- DIV:
  - Restoring divide on magnitudes. Takes 32/DIV_ITER_PER_CYCLE cycles, then a sign-fix edge writes lo=quotient, hi=remainder, then go to FIN.
  - DIV rounding: quotient truncates toward zero; remainder takes the sign of the dividend.
  - Divide by zero: skip iteration. Next edge writes lo=32'hFFFFFFFF, hi=operandA; go to FIN.
  - DIV of 32'h80000000 by 32'hFFFFFFFF: lo=32'h80000000, hi=0. No exception is raised.
- FIN: done=1 for exactly this cycle; go to IDLE. A start in FIN is ignored; the core is still stalled by the preceding busy.
- start while busy=1 is ignored and has no effect on the operation in flight.
- Operands are latched at accept; later changes on operandA/B do not affect the result.
- hi/lo hold their previous values for the whole operation; they update only at the completion edge.

Optional Feature:
- Macro: MULT_DIV_MADD_EN.
- Defined: adds MADD, MADDU, MSUB, MSUBU (op codes 8..11). These take the same MUL path and latency, then write {hi,lo}<={hi,lo}±product using the HI/LO value captured at accept. The 64-bit sum wraps modulo 2^64.
- Undefined: codes 8..11 are treated as NONE (ignored). No accumulator adder is synthesised.

Decomposition:
- Shared package mips_pkg (common.vh), existing Vec32/Vec5 types:
  - `typedef enum logic [3:0] MdOp`: NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6, MADD=8, MADDU=9, MSUB=10, MSUBU=11.
  - Vec64 typedef.
  - MdState enum.
- Sub-module `restoring_divider`: unsigned magnitude core with start/busy/done, quotient and remainder outputs. Sign handling stays in mult_div_unit.

Test Plan:
- Reset mid-DIV: start DIV 100/7, assert reset 5 cycles later → hi=lo=0, busy=0, no done pulse.
- MULT signed, MUL_LATENCY=4: A=-3 (32'hFFFFFFFD), B=5 → busy=1 for 4 cycles; then hi=32'hFFFFFFFF, lo=32'hFFFFFFF1, done pulse.
- MULTU: A=32'hFFFFFFFF, B=2 → hi=1, lo=32'hFFFFFFFE.
- DIV signed:
  - A=-7, B=2 → lo=-3 (32'hFFFFFFFD), hi=-1. busy for 32 cycles with DIV_ITER_PER_CYCLE=1, then done.
  - A=32'h80000000, B=-1 → lo=32'h80000000, hi=0.
- DIVU by zero and ignored start: A=42, B=0 → lo=32'hFFFFFFFF, hi=42. A MULT start issued while busy is ignored and hi/lo are unchanged by it.
- MTHI/MTLO then MADD (macro on): MTHI 0, MTLO 32'hFFFFFFFF, MADD 1×1 → hi=1, lo=0. With the macro off, the same MADD leaves hi=0, lo=32'hFFFFFFFF.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS core types: GPR vector widths, HI/LO unit op codes and FSM states.
package mips_pkg;

    typedef logic [31:0] Vec32;
    typedef logic [4:0]  Vec5;
    typedef logic [63:0] Vec64;

    typedef enum logic [3:0] {
        NONE  = 4'd0,
        MULT  = 4'd1,
        MULTU = 4'd2,
        DIV   = 4'd3,
        DIVU  = 4'd4,
        MTHI  = 4'd5,
        MTLO  = 4'd6,
        MADD  = 4'd8,
        MADDU = 4'd9,
        MSUB  = 4'd10,
        MSUBU = 4'd11
    } MdOp;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIN  = 2'd3
    } MdState;

    function automatic Vec32 mag32(input Vec32 v, input logic is_signed);
        return (is_signed && v[31]) ? (32'd0 - v) : v;
    endfunction

endpackage

// File: rtl/restoring_divider.sv
// Unsigned 32-bit restoring divider; the first group of quotient bits is resolved
// on the start edge so the result is registered after 32/ITER_PER_CYCLE edges.
module restoring_divider
    import mips_pkg::*;
#(
    parameter int ITER_PER_CYCLE = 1
) (
    input  logic clock,
    input  logic reset,
    input  logic start_i,
    input  Vec32 dividend_i,
    input  Vec32 divisor_i,
    output logic busy_o,
    output logic done_o,
    output Vec32 quotient_o,
    output Vec32 remainder_o
);

    localparam int STEPS = 32 / ITER_PER_CYCLE;

    logic        busy_q;
    logic [5:0]  cnt_q;
    Vec32        rem_q, qd_q, dvs_q;
    Vec32        rem_n, qd_n, dvs_src;
    logic [32:0] trial;

    // qd holds the not-yet-consumed dividend bits and collects quotient bits from the bottom
    always_comb begin
        rem_n   = start_i ? '0 : rem_q;
        qd_n    = start_i ? dividend_i : qd_q;
        dvs_src = start_i ? divisor_i : dvs_q;
        trial   = '0;
        for (int i = 0; i < ITER_PER_CYCLE; i++) begin
            trial = {rem_n, qd_n[31]} - {1'b0, dvs_src};
            if (!trial[32]) begin
                rem_n = trial[31:0];
                qd_n  = {qd_n[30:0], 1'b1};
            end else begin
                rem_n = {rem_n[30:0], qd_n[31]};
                qd_n  = {qd_n[30:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            rem_q  <= '0;
            qd_q   <= '0;
            dvs_q  <= '0;
        end else if (start_i) begin
            busy_q <= 1'b1;
            cnt_q  <= 6'(STEPS - 1);
            rem_q  <= rem_n;
            qd_q   <= qd_n;
            dvs_q  <= divisor_i;
        end else if (busy_q) begin
            if (cnt_q == 6'd0) begin
                busy_q <= 1'b0;
            end else begin
                cnt_q <= cnt_q - 6'd1;
                rem_q <= rem_n;
                qd_q  <= qd_n;
            end
        end
    end

    assign busy_o      = busy_q;
    assign done_o      = busy_q && (cnt_q == 6'd0);
    assign quotient_o  = qd_q;
    assign remainder_o = rem_q;

endmodule

// File: rtl/mult_div_unit.sv
// HI/LO multiply/divide unit behind the GPR read ports; stalls the core via busy.
// Build option MULT_DIV_MADD_EN adds MADD/MADDU/MSUB/MSUBU accumulate ops.
//   state   | meaning
//   ST_IDLE | waiting; MTHI/MTLO write here
//   ST_MUL  | multiply latency countdown
//   ST_DIV  | divider iterating (or divide-by-zero shortcut)
//   ST_FIN  | done pulse, new HI/LO visible
module mult_div_unit
    import mips_pkg::*;
#(
    parameter int MUL_LATENCY        = 4,
    parameter int DIV_ITER_PER_CYCLE = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  op,
    input  logic [31:0] operandA,
    input  logic [31:0] operandB,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    MdState     state_q, state_d;
    Vec32       hi_q, hi_d, lo_q, lo_d;
    Vec32       a_q, a_d, b_q, b_d;
    logic [3:0] op_q, op_d;
    logic [3:0] cnt_q, cnt_d;
`ifdef MULT_DIV_MADD_EN
    Vec64       acc_q, acc_d;
`endif

    logic is_mul_op, is_div_op, accept;
    logic div_start, div_busy, div_done;
    Vec32 div_quo, div_rem, q_fix, r_fix;
    logic mul_signed, div_signed_q;
    Vec64 ext_a, ext_b, prod, mul_result;

    always_comb begin
        is_mul_op = 1'b0;
        is_div_op = 1'b0;
        case (op)
            MULT, MULTU: is_mul_op = 1'b1;
`ifdef MULT_DIV_MADD_EN
            MADD, MADDU, MSUB, MSUBU: is_mul_op = 1'b1;
`endif
            DIV, DIVU:   is_div_op = 1'b1;
            default: ;
        endcase
    end

    assign accept    = (state_q == ST_IDLE) && start && (is_mul_op || is_div_op);
    assign div_start = accept && is_div_op && (operandB != 32'd0);

    restoring_divider #(
        .ITER_PER_CYCLE(DIV_ITER_PER_CYCLE)
    ) u_div (
        .clock       (clock),
        .reset       (reset),
        .start_i     (div_start),
        .dividend_i  (mag32(operandA, op == DIV)),
        .divisor_i   (mag32(operandB, op == DIV)),
        .busy_o      (div_busy),
        .done_o      (div_done),
        .quotient_o  (div_quo),
        .remainder_o (div_rem)
    );

    // Quotient truncates toward zero; remainder follows the dividend's sign
    assign div_signed_q = (op_q == DIV);
    assign q_fix = (div_signed_q && (a_q[31] ^ b_q[31])) ? (32'd0 - div_quo) : div_quo;
    assign r_fix = (div_signed_q && a_q[31]) ? (32'd0 - div_rem) : div_rem;

`ifdef MULT_DIV_MADD_EN
    assign mul_signed = (op_q == MULT) || (op_q == MADD) || (op_q == MSUB);
`else
    assign mul_signed = (op_q == MULT);
`endif
    assign ext_a = mul_signed ? {{32{a_q[31]}}, a_q} : {32'd0, a_q};
    assign ext_b = mul_signed ? {{32{b_q[31]}}, b_q} : {32'd0, b_q};
    assign prod  = ext_a * ext_b;

    always_comb begin
        mul_result = prod;
`ifdef MULT_DIV_MADD_EN
        case (op_q)
            MADD, MADDU: mul_result = acc_q + prod;
            MSUB, MSUBU: mul_result = acc_q - prod;
            default:     mul_result = prod;
        endcase
`endif
    end

    always_comb begin
        state_d = state_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
`ifdef MULT_DIV_MADD_EN
        acc_d   = acc_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (is_mul_op || is_div_op) begin
                        a_d     = operandA;
                        b_d     = operandB;
                        op_d    = op;
                        cnt_d   = 4'(MUL_LATENCY - 1);
`ifdef MULT_DIV_MADD_EN
                        acc_d   = {hi_q, lo_q};
`endif
                        state_d = is_mul_op ? ST_MUL : ST_DIV;
                    end else if (op == MTHI) begin
                        hi_d = operandA;
                    end else if (op == MTLO) begin
                        lo_d = operandA;
                    end
                end
            end
            ST_MUL: begin
                if (cnt_q == 4'd0) begin
                    {hi_d, lo_d} = mul_result;
                    state_d      = ST_FIN;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_DIV: begin
                if (b_q == 32'd0) begin
                    lo_d    = 32'hFFFF_FFFF;
                    hi_d    = a_q;
                    state_d = ST_FIN;
                end else if (div_done) begin
                    lo_d    = q_fix;
                    hi_d    = r_fix;
                    state_d = ST_FIN;
                end
            end
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            hi_q    <= '0;
            lo_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            cnt_q   <= '0;
`ifdef MULT_DIV_MADD_EN
            acc_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
`ifdef MULT_DIV_MADD_EN
            acc_q   <= acc_d;
`endif
        end
    end

    assign busy = accept || (state_q == ST_MUL) || (state_q == ST_DIV) || div_busy;
    assign done = (state_q == ST_FIN);
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
